// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, W-bit registered multiplexer with valid/ready
// handshakes on every input channel and a one-entry output register.
//
// Two selection modes:
//   mode_i = 0 : fixed select, channel sel_i is granted when it is valid.
//   mode_i = 1 : round-robin, the search starts just after the last
//                round-robin winner (rr_ptr_q) and wraps modulo CHANNELS.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   in_data_i    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid_i   per-channel valid
//   in_ready_o   per-channel accept strobe (one-hot or zero), combinational
//   mode_i       0 = fixed select, 1 = round-robin
//   sel_i        channel index used in fixed-select mode
//   out_data_o   registered output word
//   out_valid_o  output register holds a valid word
//   out_ready_i  consumer takes the output word this cycle
//   out_chan_o   source channel of out_data_o
module rr_arb_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [CHANNELS*WIDTH-1:0] in_data_i,
   input  logic [CHANNELS-1:0]       in_valid_i,
   output logic [CHANNELS-1:0]       in_ready_o,
   input  logic                      mode_i,
   input  logic [SEL_W-1:0]          sel_i,
   output logic [WIDTH-1:0]          out_data_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [SEL_W-1:0]          out_chan_o
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [SEL_W-1:0]   chan_q,  chan_d;
   logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic               grant_vld_s;
   logic [SEL_W-1:0]   grant_idx_s;
   logic               can_accept_s;
   logic               xfer_s;
   logic [WIDTH-1:0]   grant_word_s;

   // Channel index reached by stepping 'step' positions past 'ptr', modulo CHANNELS.
   function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] ptr, input int step);
      int unsigned idx;
      idx = (int'(ptr) + step) % CHANNELS;
      return idx[SEL_W-1:0];
   endfunction

   // Grant decision: fixed select or first requester after rr_ptr_q.
   always_comb begin
      logic [SEL_W-1:0] cand;
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      cand        = '0;
      if (mode_i == 1'b0) begin
         // An out-of-range sel (non power-of-two CHANNELS) never grants.
         if (int'(sel_i) < CHANNELS) begin
            if (in_valid_i[sel_i]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = sel_i;
            end else begin
               grant_vld_s = 1'b0;
            end
         end else begin
            grant_vld_s = 1'b0;
         end
      end else begin
         for (int k = 1; k <= CHANNELS; k++) begin
            cand = rr_index(rr_ptr_q, k);
            if (!grant_vld_s && in_valid_i[cand]) begin
               grant_vld_s = 1'b1;
               grant_idx_s = cand;
            end else begin
               grant_vld_s = grant_vld_s;
            end
         end
      end
   end

   // The output register can take a word when empty or when being drained this cycle.
   always_comb begin
      can_accept_s = (state_q == ST_EMPTY) || out_ready_i;
      xfer_s       = can_accept_s && grant_vld_s;
      grant_word_s = in_data_i[int'(grant_idx_s)*WIDTH +: WIDTH];
   end

   // One-hot accept strobe towards the granted producer.
   always_comb begin
      in_ready_o = '0;
      if (xfer_s) begin
         in_ready_o[grant_idx_s] = 1'b1;
      end else begin
         in_ready_o = '0;
      end
   end

   // Output register next state: load on transfer, drop valid on a drain without refill.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      chan_d   = chan_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_EMPTY: begin
            if (xfer_s) begin
               state_d = ST_FULL;
               data_d  = grant_word_s;
               chan_d  = grant_idx_s;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (xfer_s) begin
               state_d = ST_FULL;
               data_d  = grant_word_s;
               chan_d  = grant_idx_s;
            end else if (out_ready_i) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      // Only round-robin transfers advance the fairness pointer.
      if (xfer_s && mode_i) begin
         rr_ptr_d = grant_idx_s;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // State, data and pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_EMPTY;
         data_q   <= '0;
         chan_q   <= '0;
         rr_ptr_q <= SEL_W'(CHANNELS - 1);
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         chan_q   <= chan_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_valid_o = (state_q == ST_FULL);
   assign out_data_o  = data_q;
   assign out_chan_o  = chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

   localparam int W  = 8;
   localparam int CH = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SW-1:0]   out_chan;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit        m_valid;
   bit [7:0]  m_data;
   int        m_chan;
   int        m_ptr;
   bit [7:0]  dat [CH];

   rr_arb_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .mode_i      (mode),
      .sel_i       (sel),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_chan_o  (out_chan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data();
      for (int i = 0; i < CH; i++) in_data[i*W +: W] = dat[i];
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_chan  = 0;
      m_ptr   = CH - 1;
   endtask

   // Winner by the rules: fixed sel, or the requester at the smallest
   // forward distance past the last round-robin winner.
   function automatic int model_grant();
      int best;
      int bd;
      int d;
      best = -1;
      bd   = CH;
      if (mode == 1'b0) begin
         if (int'(sel) < CH && in_valid[sel]) best = int'(sel);
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (in_valid[c]) begin
               d = (c - m_ptr - 1 + 2*CH) % CH;
               if (d < bd) begin
                  bd   = d;
                  best = c;
               end
            end
         end
      end
      return best;
   endfunction

   // One clock: compare against the model at negedge, advance the model at the edge.
   task automatic tick();
      int       g;
      bit       can;
      bit [3:0] exp_rdy;
      @(negedge clk);
      g       = model_grant();
      can     = !m_valid || out_ready;
      exp_rdy = 4'b0000;
      if (can && g >= 0) exp_rdy[g] = 1'b1;
      chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("m_out_data", 32'(out_data), 32'(m_data));
         chk("m_out_chan", 32'(out_chan), 32'(m_chan));
      end
      @(posedge clk);
      if (can && g >= 0) begin
         m_valid = 1'b1;
         m_data  = dat[g];
         m_chan  = g;
         if (mode) m_ptr = g;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_chan", 32'(out_chan), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = 2'd0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      for (int i = 0; i < CH; i++) dat[i] = 8'h10 + 8'(i);
      set_data();

      // fixed select of channel 2
      do_reset();
      dat[2]    = 8'hA5;
      set_data();
      mode      = 1'b0;
      sel       = 2'd2;
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      chk("t1_in_ready", 32'(in_ready), 32'h4);
      tick();
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_data", 32'(out_data), 32'hA5);
      chk("t1_out_chan", 32'(out_chan), 32'd2);
      dat[2]    = 8'h12;
      set_data();

      // round-robin, continuous flow
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t2_out_valid", 32'(out_valid), 32'd1);
         chk("t2_out_chan", 32'(out_chan), 32'(i % 4));
         chk("t2_out_data", 32'(out_data), 32'h10 + 32'(i % 4));
      end

      // stall for three cycles after the first word
      do_reset();
      tick();
      chk("t3_first", 32'(out_data), 32'h10);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall_rdy", 32'(in_ready), 32'd0);
         tick();
         chk("t3_stall_data", 32'(out_data), 32'h10);
         chk("t3_stall_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("t3_release_data", 32'(out_data), 32'h11);
      chk("t3_release_chan", 32'(out_chan), 32'd1);

      // single requester, then wrap to channel 0
      do_reset();
      in_valid = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_only3", 32'(out_chan), 32'd3);
      end
      in_valid = 4'b1001;
      tick();
      chk("t4_wrap", 32'(out_chan), 32'd0);

      // fixed select of an idle channel drains; then switch sel
      mode     = 1'b0;
      sel      = 2'd1;
      in_valid = 4'b1101;
      #1;
      chk("t5_no_grant", 32'(in_ready), 32'd0);
      tick();
      chk("t5_drained", 32'(out_valid), 32'd0);
      sel = 2'd3;
      tick();
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_chan", 32'(out_chan), 32'd3);
      chk("t5_data", 32'(out_data), 32'h13);

      // asynchronous reset while holding a word
      do_reset();
      mode     = 1'b1;
      in_valid = 4'b1111;
      tick();
      tick();
      tick();
      chk("t6_held", 32'(out_data), 32'h12);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("t6_async_valid", 32'(out_valid), 32'd0);
      chk("t6_async_data", 32'(out_data), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("t6_first_rr", 32'(out_chan), 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < CH; i++) dat[i] = 8'($urandom);
         set_data();
         in_valid  = 4'($urandom);
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a one-entry output register.
- Two modes:
  - Fixed select: an external `sel` picks the channel, as in a classic mux.
  - Round-robin: the block arbitrates fairly among the requesting channels.
- Sits between several producer blocks and a single shared consumer (display driver, UART, shared bus). Successor to the team's 1-bit combinational mux.

Parameters:
- WIDTH, 8, data width per channel in bits (1..32).
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of sel/out_chan; must equal ceil(log2(CHANNELS)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  bit i: channel i presents data.
- in_ready  out  CHANNELS  bit i: channel i's word is accepted this cycle (one-hot or zero).
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- out_data  out  WIDTH  registered output word.
- out_valid  out  1  out_data/out_chan hold a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_chan  out  SEL_W  source channel index of out_data.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1. The first round-robin search therefore starts at channel 0.
- Output register state machine, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = EMPTY, or (FULL and out_ready). This is combinational and includes the same-cycle drain-and-refill case.
- Grant, combinational:
  - mode=0: grant channel sel iff in_valid[sel]=1. If sel >= CHANNELS there is no grant.
  - mode=1: grant the first channel with in_valid=1, searching rr_ptr+1, rr_ptr+2, ... modulo CHANNELS.
- in_ready[g] = can_accept and a grant exists. All other in_ready bits are 0. No grant means in_ready is all zero.
- Transfer on clock edge when in_ready[g]=1:
  - out_data <= word g, out_chan <= g, out_valid <= 1 (state FULL).
  - In mode=1 only, rr_ptr <= g.
  - Latency is 1 cycle from accepted input to out_valid.
- Drain with no refill (FULL, out_ready=1, no grant): out_valid <= 0 (EMPTY). out_data and out_chan hold their last values.
- Stall (FULL, out_ready=0): out_data, out_chan and out_valid are held stable. in_ready is all zero.
- Throughput: one word per cycle when out_ready is held at 1 and requests are continuous.
- rr_ptr changes only on an accepted transfer in mode=1. mode=0 transfers never move it.
- Mode or sel change: takes effect at the next grant decision. A word already in the output register is unaffected. No data is lost or duplicated.
- Wrap-around: from rr_ptr=CHANNELS-1 the search starts at 0. When only one channel requests, it is granted every cycle regardless of rr_ptr.
- Reset mid-operation: the held word is discarded, out_valid drops immediately (asynchronous), rr_ptr returns to CHANNELS-1.
- in_valid, in_data, sel and mode are sampled only at the edge. Producers must hold data until their in_ready bit is seen at 1.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100 in cycle 0; out_valid=1, out_data=8'hA5, out_chan=2 in cycle 1.
- mode=1, all four channels valid with data 8'h10/11/12/13, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; one word per cycle with no gaps.
- mode=1, all valid, out_ready held 0 for 3 cycles after the first word -> out_data=8'h10 held stable, in_ready=0 throughout; on release the next word is ch1 (8'h11) with no word skipped.
- mode=1, only ch3 valid, then ch3 and ch0 valid -> ch3 granted repeatedly, then ch0 granted after the wrap from rr_ptr=3.
- mode=0, sel=1, in_valid[1]=0, others valid -> no grant, in_ready=0, out_valid falls to 0 after draining; sel set to 3 -> ch3 transferred next cycle.
- Assert rst while FULL with out_data=8'h12 -> out_valid=0 and out_data=0 immediately (mid-cycle); after release, the first round-robin grant is ch0.
